gpio_bank: RTL and testbench
============================

GPIO_BANK -- requirements
Module: gpio_bank

Interface
REQ-001 Parameter WIDTH, default 8: number of pins, legal range 1..32.
REQ-002 Parameter SYNC_STAGES, default 2: input synchroniser depth, legal range 2..4.
REQ-003 Parameter DEBOUNCE_W, default 16: width of the debounce period register and of the per-pin counters.
REQ-004 Parameter DEBOUNCE_RESET, default 0: reset value of the DEBOUNCE register.
REQ-005 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-006 io_sys_clock  in  1  single clock; all state on rising edge.
REQ-007 io_sys_reset  in  1  asynchronous reset, active-low (0 = reset).
REQ-008 io_bus_valid  in  1  bus access request, one cycle per access.
REQ-009 io_bus_write  in  1  1 = write, 0 = read; sampled with valid.
REQ-010 io_bus_addr  in  3  register index.
REQ-011 io_bus_wdata  in  32  write data; bits above WIDTH (or DEBOUNCE_W for DEBOUNCE) ignored.
REQ-012 io_bus_rdata  out  32  read data; unused upper bits 0.
REQ-013 io_bus_ready  out  1  access-complete strobe.
REQ-014 io_pins_read  in  WIDTH  raw pad inputs, asynchronous.
REQ-015 io_pins_write  out  WIDTH  pad output values.
REQ-016 io_pins_writeEnable  out  WIDTH  pad output enables (1 = drive).
REQ-017 io_irq  out  1  level interrupt.

Function
REQ-018 Register map: 0 IN (RO, debounced pin state); 1 OUT; 2 OE; 3 OD (open-drain select); 4 RISE_EN; 5 FALL_EN; 6 PENDING (read, write-1-to-clear); 7 DEBOUNCE (period, DEBOUNCE_W bits).
REQ-019 Bus timing: io_bus_ready pulses high exactly one cycle after each valid cycle; io_bus_rdata holds the addressed value during that ready cycle and is 0 otherwise.
REQ-020 A register write takes effect on the clock edge that samples valid; a write to IN is ignored.
REQ-021 Writes to PENDING clear only the bits set in wdata; zero bits leave PENDING unchanged.
REQ-022 Push-pull pin (OD=0): writeEnable = OE, write = OUT.
REQ-023 Open-drain pin (OD=1): write = 0, writeEnable = OE AND NOT OUT.
REQ-024 Pad outputs are combinational from the registers, so a write is visible on the pins the cycle after the write edge.
REQ-025 Each pin passes through a SYNC_STAGES flop chain; the synchronised value (sync) changes SYNC_STAGES edges after a stable pad change.
REQ-026 Per-pin debounce: a counter holds 0 while sync equals stable and increments on each edge where they differ.
REQ-027 Stable update: on the edge where counter+1 >= max(DEBOUNCE,1), stable takes sync and the counter returns to 0.
REQ-028 Any cycle where sync equals stable again before the threshold returns the counter to 0 with no update, so glitches shorter than DEBOUNCE cycles are rejected.
REQ-029 IN reads the stable value of each pin.
REQ-030 A 0->1 stable transition sets PENDING[i] if RISE_EN[i]; a 1->0 transition sets PENDING[i] if FALL_EN[i]; both enabled gives both edges.
REQ-031 If a set and a W1C of the same PENDING bit occur on one edge, the set wins.
REQ-032 io_irq = OR of PENDING bits, registered-free from PENDING.
REQ-033 Changing DEBOUNCE mid-count applies to the next comparison; no counter reset occurs.

Reset
REQ-034 During reset, all registers are 0 except DEBOUNCE = DEBOUNCE_RESET.
REQ-035 During reset, synchroniser flops, stable values and counters are 0.
REQ-036 During reset, outputs are: io_bus_ready 0, io_bus_rdata 0, io_pins_writeEnable 0, io_pins_write 0, io_irq 0.
REQ-037 Reset assertion mid-access aborts the access with no ready pulse.
REQ-038 After reset release, pins held high propagate to IN without setting PENDING, because the edge enables are 0.

Verification
REQ-039 DEBOUNCE=0, RISE_EN[0]=1, pin0 0->1: IN[0]=1 after SYNC_STAGES+1 edges (3 at default), then PENDING=0x01 and io_irq=1.
REQ-040 DEBOUNCE=10: pin3 high-pulse of 9 cycles gives IN unchanged with no pending; a 10-cycle hold gives IN[3]=1 exactly 10 edges after sync rises.
REQ-041 OD=0x04, OE=0x04: OUT[2]=0 gives writeEnable[2]=1 and write[2]=0; OUT[2]=1 gives writeEnable[2]=0.
REQ-042 PENDING=0x03, write 0x01 to addr 6: PENDING=0x02 and irq stays 1; then a W1C on bit1 coincident with a new falling edge on pin1 (FALL_EN[1]=1) leaves PENDING=0x02.
REQ-043 Read of addr 7 after reset returns DEBOUNCE_RESET with ready exactly 1 cycle after valid; writing OUT=0xFF while WIDTH=4 reads back 0x0F.
REQ-044 Reset asserted mid-debounce (counter 5 of 10) clears all state; pin high after release is re-debounced from 0 and gives no pending.

Source files
------------

// File: rtl/gpio_bank.sv
// gpio_bank: WIDTH-pin general purpose I/O bank with a small register file.
// Each input pin is synchronised and debounced. Qualified edges raise
// write-1-to-clear pending bits that drive a level interrupt. Each output
// pin is push-pull or open-drain.
// DEBOUNCE_W is expected to be at most 32 so the period fits the bus word.
module gpio_bank #(
  parameter int WIDTH          = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int DEBOUNCE_W     = 16,
  parameter int DEBOUNCE_RESET = 0
) (
  input  logic             io_sys_clock,
  input  logic             io_sys_reset,
  input  logic             io_bus_valid,
  input  logic             io_bus_write,
  input  logic [2:0]       io_bus_addr,
  input  logic [31:0]      io_bus_wdata,
  output logic [31:0]      io_bus_rdata,
  output logic             io_bus_ready,
  input  logic [WIDTH-1:0] io_pins_read,
  output logic [WIDTH-1:0] io_pins_write,
  output logic [WIDTH-1:0] io_pins_writeEnable,
  output logic             io_irq
);

  localparam logic [2:0] ADDR_IN       = 3'd0;
  localparam logic [2:0] ADDR_OUT      = 3'd1;
  localparam logic [2:0] ADDR_OE       = 3'd2;
  localparam logic [2:0] ADDR_OD       = 3'd3;
  localparam logic [2:0] ADDR_RISE_EN  = 3'd4;
  localparam logic [2:0] ADDR_FALL_EN  = 3'd5;
  localparam logic [2:0] ADDR_PENDING  = 3'd6;
  localparam logic [2:0] ADDR_DEBOUNCE = 3'd7;

  // Counter increment widened by one bit so the threshold compare cannot wrap.
  function automatic logic [DEBOUNCE_W:0] cnt_bump(input logic [DEBOUNCE_W-1:0] c);
    return {1'b0, c} + {{DEBOUNCE_W{1'b0}}, 1'b1};
  endfunction

  // Register file
  logic [WIDTH-1:0]      out_q, oe_q, od_q, rise_en_q, fall_en_q, pending_q;
  logic [DEBOUNCE_W-1:0] debounce_q;

  // Input path state
  logic [WIDTH-1:0]      sync_p [SYNC_STAGES];
  logic [WIDTH-1:0]      stable_q;
  logic [DEBOUNCE_W-1:0] cnt_q [WIDTH];

  // Bus response
  logic                  vld_p1;
  logic [31:0]           rdata_p1;

  // Combinational helpers
  logic [WIDTH-1:0]      sync_w;
  logic [WIDTH-1:0]      stable_nxt;
  logic [DEBOUNCE_W-1:0] cnt_nxt [WIDTH];
  logic [DEBOUNCE_W:0]   inc_w [WIDTH];
  logic [DEBOUNCE_W:0]   thresh;
  logic [WIDTH-1:0]      edge_set;
  logic [WIDTH-1:0]      w1c_mask;
  logic                  bus_wr;
  logic [31:0]           rd_val;
  logic                  unused_wdata;

  assign unused_wdata = ^io_bus_wdata;
  assign sync_w       = sync_p[SYNC_STAGES-1];
  assign bus_wr       = io_bus_valid & io_bus_write;

  // A period of 0 behaves like 1: the stable value follows sync after one edge.
  always_comb begin
    thresh = {1'b0, debounce_q};
    if (debounce_q == '0) thresh = {{DEBOUNCE_W{1'b0}}, 1'b1};
  end

  // Per-pin debounce decision: count while sync differs, commit at threshold.
  always_comb begin
    stable_nxt = stable_q;
    for (int i = 0; i < WIDTH; i++) begin
      inc_w[i]   = cnt_bump(cnt_q[i]);
      cnt_nxt[i] = '0;
      if (sync_w[i] != stable_q[i]) begin
        if (inc_w[i] >= thresh) stable_nxt[i] = sync_w[i];
        else                    cnt_nxt[i]    = inc_w[i][DEBOUNCE_W-1:0];
      end
    end
  end

  // Qualified edges and write-1-to-clear mask for the pending register.
  always_comb begin
    edge_set = ( stable_nxt & ~stable_q & rise_en_q)
             | (~stable_nxt &  stable_q & fall_en_q);
    w1c_mask = '0;
    if (bus_wr && io_bus_addr == ADDR_PENDING) w1c_mask = io_bus_wdata[WIDTH-1:0];
  end

  // Read mux for the addressed register, zero-extended to the bus width.
  always_comb begin
    rd_val = '0;
    case (io_bus_addr)
      ADDR_IN:       rd_val = 32'(stable_q);
      ADDR_OUT:      rd_val = 32'(out_q);
      ADDR_OE:       rd_val = 32'(oe_q);
      ADDR_OD:       rd_val = 32'(od_q);
      ADDR_RISE_EN:  rd_val = 32'(rise_en_q);
      ADDR_FALL_EN:  rd_val = 32'(fall_en_q);
      ADDR_PENDING:  rd_val = 32'(pending_q);
      ADDR_DEBOUNCE: rd_val = 32'(debounce_q);
      default:       rd_val = '0;
    endcase
  end

  // Register writes; a new edge beats a simultaneous clear of the same bit.
  always_ff @(posedge io_sys_clock or negedge io_sys_reset) begin
    if (!io_sys_reset) begin
      out_q      <= '0;
      oe_q       <= '0;
      od_q       <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      pending_q  <= '0;
      debounce_q <= DEBOUNCE_W'(DEBOUNCE_RESET);
    end else begin
      if (bus_wr) begin
        case (io_bus_addr)
          ADDR_OUT:      out_q      <= io_bus_wdata[WIDTH-1:0];
          ADDR_OE:       oe_q       <= io_bus_wdata[WIDTH-1:0];
          ADDR_OD:       od_q       <= io_bus_wdata[WIDTH-1:0];
          ADDR_RISE_EN:  rise_en_q  <= io_bus_wdata[WIDTH-1:0];
          ADDR_FALL_EN:  fall_en_q  <= io_bus_wdata[WIDTH-1:0];
          ADDR_DEBOUNCE: debounce_q <= io_bus_wdata[DEBOUNCE_W-1:0];
          default:       ;
        endcase
      end
      pending_q <= (pending_q & ~w1c_mask) | edge_set;
    end
  end

  // Synchroniser chain for the asynchronous pad inputs.
  always_ff @(posedge io_sys_clock or negedge io_sys_reset) begin
    if (!io_sys_reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_p[s] <= '0;
    end else begin
      sync_p[0] <= io_pins_read;
      for (int s = 1; s < SYNC_STAGES; s++) sync_p[s] <= sync_p[s-1];
    end
  end

  // Debounced pin state and per-pin counters.
  always_ff @(posedge io_sys_clock or negedge io_sys_reset) begin
    if (!io_sys_reset) begin
      stable_q <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      stable_q <= stable_nxt;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_nxt[i];
    end
  end

  // Bus response: ready one cycle after valid, read data only for reads.
  always_ff @(posedge io_sys_clock or negedge io_sys_reset) begin
    if (!io_sys_reset) begin
      vld_p1   <= 1'b0;
      rdata_p1 <= '0;
    end else begin
      vld_p1   <= io_bus_valid;
      rdata_p1 <= (io_bus_valid && !io_bus_write) ? rd_val : '0;
    end
  end

  assign io_bus_ready        = vld_p1;
  assign io_bus_rdata        = rdata_p1;
  assign io_pins_write       = out_q & ~od_q;
  assign io_pins_writeEnable = oe_q & ~(od_q & out_q);
  assign io_irq              = |pending_q;

endmodule

// File: tb/tb_gpio_bank.sv
// Directed bench for gpio_bank: a default 8-pin instance plus a 4-pin
// instance with a non-zero debounce reset value sharing the same bus.
module tb_gpio_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid, wr;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata, rdata4;
  logic        ready, ready4;
  logic [7:0]  pins, pwrite, pwe;
  logic [3:0]  pins4, pwrite4, pwe4;
  logic        irq, irq4;
  logic [31:0] rd4;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  gpio_bank #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_W(16), .DEBOUNCE_RESET(0)) dut (
    .io_sys_clock(clk), .io_sys_reset(rst_n),
    .io_bus_valid(valid), .io_bus_write(wr), .io_bus_addr(addr), .io_bus_wdata(wdata),
    .io_bus_rdata(rdata), .io_bus_ready(ready),
    .io_pins_read(pins), .io_pins_write(pwrite), .io_pins_writeEnable(pwe),
    .io_irq(irq)
  );

  gpio_bank #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_W(16), .DEBOUNCE_RESET(5)) dut4 (
    .io_sys_clock(clk), .io_sys_reset(rst_n),
    .io_bus_valid(valid), .io_bus_write(wr), .io_bus_addr(addr), .io_bus_wdata(wdata),
    .io_bus_rdata(rdata4), .io_bus_ready(ready4),
    .io_pins_read(pins4), .io_pins_write(pwrite4), .io_pins_writeEnable(pwe4),
    .io_irq(irq4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    valid = 1'b1; wr = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    valid = 1'b0; wr = 1'b0; wdata = '0;
  endtask

  task automatic bus_read(input logic [2:0] a, input logic [31:0] exp, input string tag);
    @(negedge clk);
    valid = 1'b1; wr = 1'b0; addr = a;
    @(negedge clk);
    valid = 1'b0;
    check({tag, "_ready"}, 32'(ready), 32'd1);
    check(tag, rdata, exp);
    rd4 = rdata4;
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    pins = '0; pins4 = '0; rd4 = '0;
    repeat (2) @(negedge clk);

    // Outputs while held in reset
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_we",    32'(pwe), 32'd0);
    check("rst_write", 32'(pwrite), 32'd0);
    check("rst_irq",   32'(irq), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // DEBOUNCE reset values, ready lasts exactly one cycle
    bus_read(3'd7, 32'd0, "deb_rst");
    check("deb_rst_w4", rd4, 32'd5);
    @(negedge clk);
    check("ready_drop", 32'(ready), 32'd0);
    check("rdata_idle", rdata, 32'd0);

    // Write data above WIDTH is dropped
    bus_write(3'd1, 32'h0000_00FF);
    bus_read(3'd1, 32'h0000_00FF, "out_rb");
    check("out_rb_w4", rd4, 32'h0000_000F);

    // Rising edge on pin0 with DEBOUNCE=0: IN follows three edges later
    bus_write(3'd4, 32'h01);
    @(negedge clk); pins = 8'h01;
    repeat (2) @(negedge clk);
    check("rise_e2_irq", 32'(irq), 32'd0);
    @(negedge clk);
    check("rise_e3_irq", 32'(irq), 32'd1);
    bus_read(3'd0, 32'h01, "rise_in");
    bus_read(3'd6, 32'h01, "rise_pend");

    // Push-pull versus open-drain pad drive
    bus_write(3'd3, 32'h04);
    bus_write(3'd2, 32'h04);
    bus_write(3'd1, 32'h00);
    check("od_low_we",  32'(pwe), 32'h04);
    check("od_low_wr",  32'(pwrite), 32'h00);
    bus_write(3'd1, 32'h04);
    check("od_high_we", 32'(pwe), 32'h00);
    check("od_high_wr", 32'(pwrite), 32'h00);
    bus_write(3'd2, 32'h06);
    bus_write(3'd1, 32'h06);
    check("mix_we",     32'(pwe), 32'h02);
    check("mix_wr",     32'(pwrite), 32'h02);

    // DEBOUNCE=10: a 9-cycle pulse on pin3 is rejected
    bus_write(3'd4, 32'h09);
    bus_write(3'd7, 32'd10);
    @(negedge clk); pins = 8'h09;
    repeat (9) @(negedge clk);
    pins = 8'h01;
    repeat (20) @(negedge clk);
    bus_read(3'd0, 32'h01, "glitch_in");
    bus_read(3'd6, 32'h01, "glitch_pend");
    bus_write(3'd6, 32'h01);
    check("w1c_irq0", 32'(irq), 32'd0);

    // A 10-cycle hold is accepted exactly 10 edges after sync rises
    @(negedge clk); pins = 8'h09;
    repeat (11) @(negedge clk);
    check("hold_e11_irq", 32'(irq), 32'd0);
    @(negedge clk);
    check("hold_e12_irq", 32'(irq), 32'd1);
    bus_read(3'd0, 32'h09, "hold_in");
    bus_read(3'd6, 32'h08, "hold_pend");

    // W1C clears selected bits; a coincident new edge wins
    bus_write(3'd6, 32'hFF);
    bus_write(3'd7, 32'd0);
    bus_write(3'd4, 32'h03);
    bus_write(3'd5, 32'h02);
    @(negedge clk); pins = 8'h08;
    repeat (5) @(negedge clk);
    pins = 8'h0B;
    repeat (5) @(negedge clk);
    bus_read(3'd6, 32'h03, "pend3");
    bus_write(3'd6, 32'h01);
    bus_read(3'd6, 32'h02, "pend_w1c");
    check("pend_w1c_irq", 32'(irq), 32'd1);
    @(negedge clk); pins = 8'h09;
    @(negedge clk);
    bus_write(3'd6, 32'h02);
    bus_read(3'd6, 32'h02, "set_wins");
    bus_write(3'd6, 32'h02);
    bus_read(3'd6, 32'h00, "pend_clear");
    check("pend_clear_irq", 32'(irq), 32'd0);

    // Reset mid-debounce (counter at 5 of 10) and mid-access
    bus_write(3'd7, 32'd10);
    bus_write(3'd4, 32'h10);
    @(negedge clk); pins = 8'h19;
    repeat (7) @(negedge clk);
    valid = 1'b1; wr = 1'b0; addr = 3'd0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("abort_ready", 32'(ready), 32'd0);
    check("abort_rdata", rdata, 32'd0);
    check("abort_we",    32'(pwe), 32'd0);
    check("abort_irq",   32'(irq), 32'd0);
    valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    bus_read(3'd0, 32'h19, "post_rst_in");
    bus_read(3'd6, 32'h00, "post_rst_pend");
    check("post_rst_irq", 32'(irq), 32'd0);
    bus_read(3'd7, 32'd0, "post_rst_deb");
    check("post_rst_deb_w4", rd4, 32'd5);
    bus_read(3'd2, 32'd0, "post_rst_oe");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
